// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: pops 16-bit samples from a FWFT FIFO
// and shifts them out MSB first, generating BCLK and LRCLK from mclk.
module i2s_tx_serializer #(
    parameter int BCLK_DIV   = 4,
    parameter int SLOT_WIDTH = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  tx_rinc,
    input  logic [DATA_WIDTH-1:0] tx_rdata,
    input  logic                  tx_rempty,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic [15:0]           underrun_cnt
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] BIT_DATA = BW'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [15:0]           urun_count;
    logic                  ss;
    logic                  wrap;
    logic                  slot_end;
    logic [BW-1:0]         bit_nxt;

    assign wrap         = (div_cnt == DIV_LAST);
    assign slot_end     = wrap && bclk && (bit_cnt == BIT_LAST);
    assign bit_nxt      = bit_cnt + BW'(1);
    assign tx_rinc      = ss && !tx_rempty && !reset;
    assign underrun_cnt = urun_count;

    // State register: IDLE until enabled, RUN while streaming.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and slot-start decode.
    always_comb begin
        state_nxt = state;
        ss        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    ss        = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable)       state_nxt = ST_IDLE;
                else if (slot_end) ss = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Clock division, slot loading and bit shifting on falling BCLK.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            urun_count <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
        end else if (ss) begin
            shreg   <= tx_rempty ? '0 : tx_rdata;
            bit_cnt <= '0;
            div_cnt <= '0;
            bclk    <= 1'b0;
            sdata   <= 1'b0;
            lrclk   <= (state == ST_RUN) ? ~lrclk : 1'b0;
            if (tx_rempty && urun_count != 16'hFFFF)
                urun_count <= urun_count + 16'd1;
        end else if (state == ST_RUN && !enable) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
        end else if (state == ST_RUN) begin
            div_cnt <= wrap ? '0 : div_cnt + DW'(1);
            if (wrap) begin
                bclk <= ~bclk;
                if (bclk) begin
                    bit_cnt <= bit_nxt;
                    if (bit_nxt <= BIT_DATA) begin
                        sdata <= shreg[DATA_WIDTH-1];
                        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        sdata <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: FIFO model, slot-level reference
// and a scoreboard that checks each serialised slot.
module tb_i2s_tx_serializer;

    localparam int BD       = 4;
    localparam int SW       = 32;
    localparam int SLOT_CYC = 2 * BD * SW;

    logic        mclk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tx_rinc;
    logic [15:0] tx_rdata;
    logic        tx_rempty;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        lr;
        logic [15:0] data;
    } exp_t;

    logic [15:0] fifo[$];
    exp_t        expq[$];

    bit          ref_run  = 1'b0;
    int          ref_t    = 0;
    bit          ref_lr   = 1'b0;
    logic [15:0] exp_urun = 16'h0;
    bit          pop_now  = 1'b0;
    logic [63:0] bits     = 64'h0;
    int          nbits    = 0;
    bit          prev_bclk = 1'b0;
    bit          lr_first = 1'b0;

    i2s_tx_serializer dut (
        .mclk         (mclk),
        .reset        (reset),
        .enable       (enable),
        .tx_rinc      (tx_rinc),
        .tx_rdata     (tx_rdata),
        .tx_rempty    (tx_rempty),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun_cnt (underrun_cnt)
    );

    always #5 mclk = ~mclk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void upd_fifo();
        tx_rempty = (fifo.size() == 0);
        tx_rdata  = tx_rempty ? 16'h0 : fifo[0];
    endfunction

    function automatic void push(logic [15:0] w);
        fifo.push_back(w);
        upd_fifo();
    endfunction

    // FIFO read side: a pop seen in a cycle removes the head after the edge.
    always begin
        logic [15:0] tmp;
        @(posedge mclk);
        #1;
        if (pop_now) begin
            pop_now = 1'b0;
            if (fifo.size() > 0) tmp = fifo.pop_front();
            upd_fifo();
        end
    end

    // Reference model and monitor, sampled on the falling mclk edge.
    always @(negedge mclk) begin
        bit          ss;
        bit          ne;
        exp_t        e;
        logic [63:0] pat;
        logic [63:0] mask;
        mask = (64'd1 << SW) - 64'd1;
        if (ref_run && !reset) begin
            chk("bclk", bclk, 64'((ref_t / BD) % 2));
            chk("lrclk", lrclk, ref_lr);
            if (bclk && !prev_bclk) begin
                if (nbits == 0) lr_first = lrclk;
                bits = {bits[62:0], sdata};
                nbits++;
                if (nbits == SW) begin
                    nbits = 0;
                    chk("slot_q", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e   = expq.pop_front();
                        pat = {48'h0, e.data} << (SW - 17);
                        chk("slot_data", bits & mask, pat);
                        chk("slot_lr", {lr_first, lrclk}, {e.lr, e.lr});
                    end
                end
            end
        end else begin
            chk("idle_out", {bclk, lrclk, sdata}, 3'b000);
        end
        prev_bclk = bclk;

        ss = !reset && enable && (!ref_run || ref_t == SLOT_CYC - 1);
        ne = (fifo.size() > 0);
        if ((ss && ne) || tx_rinc) chk("tx_rinc", tx_rinc, ss && ne);
        pop_now = tx_rinc;

        if (reset) begin
            ref_run  = 1'b0;
            ref_t    = 0;
            exp_urun = 16'h0;
            expq.delete();
            nbits = 0;
        end else if (ss) begin
            if (ref_run) chk("slot_bits", nbits, 0);
            chk("underrun_cnt", underrun_cnt, exp_urun);
            if (!ne && exp_urun != 16'hFFFF) exp_urun = exp_urun + 16'd1;
            ref_lr  = ref_run ? !ref_lr : 1'b0;
            ref_run = 1'b1;
            ref_t   = 0;
            expq.push_back('{lr: ref_lr, data: ne ? fifo[0] : 16'h0});
        end else if (ref_run && !enable) begin
            ref_run = 1'b0;
            ref_t   = 0;
            expq.delete();
            nbits = 0;
        end else if (ref_run) begin
            ref_t++;
        end
    end

    task automatic wait_bit(input bit lr, input int k);
        int n;
        n = 0;
        do begin
            @(posedge mclk);
            #1;
            n++;
        end while (!(ref_run && ref_lr == lr && ref_t == k * 2 * BD) && n < 3000);
        chk("wait_bit", n < 3000, 1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        push(16'hA5F0);
        push(16'h0F0F);
        repeat (3) begin
            @(posedge mclk);
            #1;
            chk("rst_rinc", tx_rinc, 0);
            chk("rst_out", {bclk, lrclk, sdata}, 0);
            chk("rst_urun", underrun_cnt, 0);
        end
        reset = 1'b0;
        #1;
        chk("first_pop", tx_rinc, 1);

        repeat (1800) @(posedge mclk);
        #1;
        chk("urun_6", underrun_cnt, 16'd6);
        push(16'h8000);

        wait_bit(1'b0, 20);
        push(16'h1234);
        push(16'h5678);

        wait_bit(1'b0, 8);
        push(16'h9ABC);
        enable = 1'b0;
        @(posedge mclk);
        #1;
        chk("dis_out", {bclk, lrclk, sdata}, 0);
        repeat (4) @(posedge mclk);
        #1;
        enable = 1'b1;
        #1;
        chk("reen_rinc", tx_rinc, 1);
        @(posedge mclk);
        #1;
        chk("reen_lr", lrclk, 0);

        for (int i = 0; i < 3; i++) push(16'($urandom));
        wait_bit(1'b0, 20);
        wait_bit(1'b1, 20);
        reset = 1'b1;
        #1;
        chk("arst_out", {bclk, lrclk, sdata}, 0);
        chk("arst_urun", underrun_cnt, 0);
        chk("arst_rinc", tx_rinc, 0);
        while (fifo.size() > 0) begin
            logic [15:0] d;
            d = fifo.pop_front();
        end
        push(16'hDEAD);
        repeat (2) @(posedge mclk);
        #1;
        reset = 1'b0;
        #1;
        chk("rel_rinc", tx_rinc, 1);

        wait_bit(1'b0, 10);
        force dut.urun_count = 16'hFFFE;
        exp_urun = 16'hFFFE;
        #1;
        release dut.urun_count;
        #1;
        chk("forced", underrun_cnt, 16'hFFFE);
        wait_bit(1'b0, 10);
        chk("urun_sat", underrun_cnt, 16'hFFFF);

        enable = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Consumes 16-bit audio samples from the TX async FIFO, on the FIFO read side in the `mclk` domain, and serialises them to the ADAU1761 DAC input as I2S.
- Generates BCLK and LRCLK by dividing `mclk`.
- Pops one FIFO word per channel slot, left first, then right.
- Emits zeros and counts underruns when the FIFO is empty.
- Sits directly downstream of the AXI-to-FIFO write block and drives its `tx_rinc`.

## Interface

Parameters:
- `BCLK_DIV`, 4: `mclk` cycles per BCLK half-period; legal range is ≥2.
- `SLOT_WIDTH`, 32: BCLK cycles per channel slot; legal range is ≥18.
- `DATA_WIDTH`, 16: sample width; fixed at 16.

Ports:
- `mclk`, in, 1: the only clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: run/stop control; synchronous to `mclk`.
- `tx_rinc`, out, 1: FIFO pop strobe, one `mclk` cycle wide.
- `tx_rdata`, in, 16: FIFO head word. The FIFO is first-word-fall-through, so this is valid whenever `tx_rempty` is 0.
- `tx_rempty`, in, 1: FIFO empty flag.
- `bclk`, out, 1: I2S bit clock.
- `lrclk`, out, 1: word select; 0 = left slot, 1 = right slot.
- `sdata`, out, 1: serial data, MSB first.
- `underrun_cnt`, out, 16: count of slots that had no sample; saturates.

## Operation

State:
- `div_cnt`: counts 0..BCLK_DIV-1.
- `bit_cnt`: counts 0..SLOT_WIDTH-1.
- Channel bit.
- 16-bit shift register.
- `running` flag.

BCLK generation (while `running`):
- `div_cnt` increments every cycle and wraps at BCLK_DIV-1.
- `bclk` toggles on the wrap.

Falling BCLK (toggle 1→0):
- `bit_cnt` advances.
- `sdata` updates, so data changes on falling edges and is sampled by the codec on rising edges.

Slot-start cycle (SS) is either:
- the IDLE cycle in which `enable`=1, or
- the running cycle with `div_cnt`=BCLK_DIV-1, `bclk`=1, `bit_cnt`=SLOT_WIDTH-1.

During SS:
- `tx_rinc` = !`tx_rempty`. This is a combinational decode of registered state plus `tx_rempty`.
- At the closing edge, the shift register loads `tx_rdata` if the FIFO was non-empty, else it loads 16'h0 and `underrun_cnt` increments (saturating at 16'hFFFF).
- At the same edge: `bit_cnt`←0, `div_cnt`←0, `bclk`←0, `sdata`←0.
- `lrclk`: from IDLE → 0; otherwise it toggles.

Slot bit mapping, as `bit_cnt` k within the slot:
- k=0: `sdata`=0 (the I2S one-bit delay).
- k=1..16: `sdata`=sample[16-k].
- k=17..SLOT_WIDTH-1: `sdata`=0.

Enable behaviour:
- `enable`=0 while running: at the next edge go to IDLE. `bclk`, `lrclk`, `sdata` ← 0, counters ← 0, and the current sample is discarded without a pop.
- `enable`=0 in IDLE: no pops and outputs held at 0.
- Re-enable always restarts at the left slot.

Reset (any time, including mid-frame) clears everything immediately: IDLE, `bclk`=`lrclk`=`sdata`=0, `underrun_cnt`=0, counters 0. `tx_rinc` is 0 during reset.

## Timing

- BCLK period = 2·BCLK_DIV `mclk` cycles. Slot = SLOT_WIDTH·2·BCLK_DIV cycles. Frame = 2·slot; defaults give 8, 256, 512.
- Exactly one pop per slot, in the SS cycle only, so two pops per frame spaced one slot apart.
- Latency from the SS cycle:
  - `lrclk`/`sdata` update at the next edge.
  - MSB appears 2·BCLK_DIV cycles after that, at the falling edge that starts bit 1.
- First-word latency from `enable` rise, with the FIFO non-empty: pop in the same cycle; the first BCLK rise is BCLK_DIV cycles after the SS edge.
- FIFO empty during SS: no pop and the slot is all zeros. Data arriving later in the slot is held for the next SS.
- `tx_rempty` changing outside SS has no effect.
- `underrun_cnt` at 16'hFFFF stays at 16'hFFFF.

## Test plan

- Reset check: assert `reset` for 3 cycles with the FIFO full → `tx_rinc`, `bclk`, `lrclk`, `sdata` all 0; `underrun_cnt`=0.
- Normal frame: FIFO preloaded with 16'hA5F0 then 16'h0F0F, `enable`=1 with defaults. Require:
  - `tx_rinc` pulses at cycle 0 and cycle 256.
  - In the left slot (`lrclk`=0), `sdata` sampled on BCLK rises gives 0,1010010111110000, then 15 zeros.
  - In the right slot (`lrclk`=1), the same pattern gives 0,0000111100001111, then 15 zeros.
- Underrun: FIFO empty for 3 frames → `sdata` constant 0, `tx_rinc` never asserted, `underrun_cnt`=6. Then push 16'h8000 → the next SS pops it, and the MSB=1 appears as bit 1 of that slot.
- Mid-slot disable: drop `enable` at `bit_cnt`=8 of the left slot → outputs all 0 on the next edge and no extra `tx_rinc`. Re-enable → `tx_rinc` in the same cycle and `lrclk`=0.
- Mid-frame reset: assert `reset` at `bit_cnt`=20 of the right slot → outputs 0 asynchronously; after release with `enable`=1, a left slot starts with a pop.
- Saturation: force `underrun_cnt` to 16'hFFFE, keep the FIFO empty for 2 slots → the count reaches 16'hFFFF and holds.
